// File: rtl/minirisc_core.sv
// minirisc_core: 8-bit multicycle MiniRISC CPU with 16 registers, a stack in
// data memory, level-sensitive interrupts and a single-master bus gate.
module minirisc_core #(
  parameter logic [7:0] RST_PC     = 8'h00,
  parameter logic [7:0] RST_SP     = 8'h7F,
  parameter logic [7:0] IRQ_VECTOR = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  cpu2pmem_addr,
  input  logic [15:0] pmem2cpu_data,
  output logic        m_bus_req,
  input  logic        m_bus_grant,
  output logic [7:0]  m_mst2slv_addr,
  output logic        m_mst2slv_wr,
  output logic        m_mst2slv_rd,
  output logic [7:0]  m_mst2slv_data,
  input  logic [7:0]  m_slv2mst_data,
  input  logic        irq,
  output logic [7:0]  SP,
  input  logic [7:0]  dbg_stack_top,
  input  logic [22:0] dbg2cpu_data,
  output logic [47:0] cpu2dbg_data
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_EXEC2 = 3'd2,
    ST_INT1  = 3'd3,
    ST_INT2  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  sp_q, sp_d;
  logic [15:0] ir_q, ir_d;
  logic        z_q, z_d, c_q, c_d, n_q, n_d, ie_q, ie_d;
  logic [7:0]  rf_q [16];
  logic [7:0]  rf_d [16];

  // Instruction fields
  logic [3:0] op_s, rd_s, rs_s, aluop_s;
  logic [7:0] imm_s, rd_val_s, rs_val_s, flags_byte_s;
  assign op_s         = ir_q[15:12];
  assign rd_s         = ir_q[11:8];
  assign rs_s         = ir_q[7:4];
  assign aluop_s      = ir_q[3:0];
  assign imm_s        = ir_q[7:0];
  assign rd_val_s     = rf_q[rd_s];
  assign rs_val_s     = rf_q[rs_s];
  assign flags_byte_s = {4'b0000, ie_q, n_q, c_q, z_q};

  // Debug-only inputs are intentionally not consumed by the core
  logic unused_inputs_s;
  assign unused_inputs_s = ^{dbg_stack_top, dbg2cpu_data};

  // ALU: immediate ops use the opcode as function, op 0xA uses aluop with rs
  logic       alu_sel_s, alu_wb_s, alu_fl_s, alu_c_s;
  logic [3:0] alu_fn_s;
  logic [7:0] alu_b_s;
  logic [8:0] alu_full_s;
  always_comb begin
    alu_sel_s  = (op_s <= 4'h6) || (op_s == 4'hA);
    alu_full_s = 9'h000;
    alu_wb_s   = 1'b0;
    alu_fl_s   = 1'b0;
    alu_c_s    = c_q;
    if (op_s == 4'hA) begin
      alu_fn_s = aluop_s;
      alu_b_s  = rs_val_s;
    end else begin
      alu_fn_s = op_s;
      alu_b_s  = imm_s;
    end
    case (alu_fn_s)
      4'h0: begin alu_full_s = {1'b0, alu_b_s}; alu_wb_s = 1'b1; end
      4'h1: begin
        alu_full_s = {1'b0, rd_val_s} + {1'b0, alu_b_s};
        alu_wb_s = 1'b1; alu_fl_s = 1'b1; alu_c_s = alu_full_s[8];
      end
      4'h2: begin
        alu_full_s = {1'b0, rd_val_s} - {1'b0, alu_b_s};
        alu_wb_s = 1'b1; alu_fl_s = 1'b1; alu_c_s = alu_full_s[8];
      end
      4'h3: begin alu_full_s = {1'b0, rd_val_s & alu_b_s}; alu_wb_s = 1'b1; alu_fl_s = 1'b1; alu_c_s = 1'b0; end
      4'h4: begin alu_full_s = {1'b0, rd_val_s | alu_b_s}; alu_wb_s = 1'b1; alu_fl_s = 1'b1; alu_c_s = 1'b0; end
      4'h5: begin alu_full_s = {1'b0, rd_val_s ^ alu_b_s}; alu_wb_s = 1'b1; alu_fl_s = 1'b1; alu_c_s = 1'b0; end
      4'h6: begin
        alu_full_s = {1'b0, rd_val_s} - {1'b0, alu_b_s};
        alu_fl_s = 1'b1; alu_c_s = alu_full_s[8];
      end
      default: begin end
    endcase
  end

  // Jump condition for op 0xE (JSR is always taken)
  logic jmp_take_s;
  always_comb begin
    case (rd_s)
      4'h0:    jmp_take_s = 1'b1;
      4'h1:    jmp_take_s = z_q;
      4'h2:    jmp_take_s = ~z_q;
      4'h3:    jmp_take_s = c_q;
      4'h4:    jmp_take_s = ~c_q;
      4'h5:    jmp_take_s = 1'b1;
      default: jmp_take_s = 1'b0;
    endcase
  end

  // Data-bus access wanted in the current state
  logic       acc_s, acc_wr_s;
  logic [7:0] acc_addr_s, acc_wdata_s;
  always_comb begin
    acc_s       = 1'b0;
    acc_wr_s    = 1'b0;
    acc_addr_s  = 8'h00;
    acc_wdata_s = 8'h00;
    case (state_q)
      ST_EXEC: begin
        case (op_s)
          4'h8: begin acc_s = 1'b1; acc_addr_s = imm_s; end
          4'h9: begin acc_s = 1'b1; acc_wr_s = 1'b1; acc_addr_s = imm_s; acc_wdata_s = rd_val_s; end
          4'hB: begin
            acc_s = 1'b1;
            if (!ir_q[0]) begin
              acc_wr_s = 1'b1; acc_addr_s = sp_q - 8'd1; acc_wdata_s = rd_val_s;
            end else begin
              acc_addr_s = sp_q;
            end
          end
          4'hE: begin
            if (rd_s == 4'h5) begin
              acc_s = 1'b1; acc_wr_s = 1'b1; acc_addr_s = sp_q - 8'd1; acc_wdata_s = pc_q;
            end else begin
              acc_s = 1'b0;
            end
          end
          4'hF: begin
            if ((rd_s == 4'h0) || (rd_s == 4'h1)) begin
              acc_s = 1'b1; acc_addr_s = sp_q;
            end else begin
              acc_s = 1'b0;
            end
          end
          default: begin end
        endcase
      end
      ST_EXEC2: begin acc_s = 1'b1; acc_addr_s = sp_q; end
      ST_INT1:  begin acc_s = 1'b1; acc_wr_s = 1'b1; acc_addr_s = sp_q - 8'd1; acc_wdata_s = pc_q; end
      ST_INT2:  begin acc_s = 1'b1; acc_wr_s = 1'b1; acc_addr_s = sp_q - 8'd1; acc_wdata_s = flags_byte_s; end
      default:  begin end
    endcase
  end

  // Fixed-priority gate: the CPU is master 0 and master 1 is tied off,
  // so the CPU's grant is simply its request qualified by the bus grant.
  logic gnt_s, stall_s;
  assign gnt_s   = acc_s & m_bus_grant & ~rst;
  assign stall_s = acc_s & ~m_bus_grant;

  // Bus outputs; reset kills any access in flight in the same cycle
  always_comb begin
    m_bus_req      = acc_s & ~rst;
    m_mst2slv_wr   = gnt_s & acc_wr_s;
    m_mst2slv_rd   = gnt_s & ~acc_wr_s;
    m_mst2slv_addr = gnt_s ? acc_addr_s : 8'h00;
    m_mst2slv_data = (gnt_s && acc_wr_s) ? acc_wdata_s : 8'h00;
  end

  // Next-state and datapath update; a stalled bus cycle changes nothing
  state_e exec_next_s;
  assign exec_next_s = (irq && ie_q) ? ST_INT1 : ST_FETCH;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    ie_d    = ie_q;
    rf_d    = rf_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = pmem2cpu_data;
        pc_d    = pc_q + 8'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (stall_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = exec_next_s;
          if (alu_sel_s) begin
            if (alu_wb_s) begin
              rf_d[rd_s] = alu_full_s[7:0];
            end else begin
              rf_d[rd_s] = rd_val_s;
            end
            if (alu_fl_s) begin
              z_d = (alu_full_s[7:0] == 8'h00);
              n_d = alu_full_s[7];
              c_d = alu_c_s;
            end else begin
              z_d = z_q;
            end
          end else begin
            case (op_s)
              4'h8: rf_d[rd_s] = m_slv2mst_data;
              4'hB: begin
                if (!ir_q[0]) begin
                  sp_d = sp_q - 8'd1;
                end else begin
                  rf_d[rd_s] = m_slv2mst_data;
                  sp_d       = sp_q + 8'd1;
                end
              end
              4'hE: begin
                if (jmp_take_s) begin
                  pc_d = imm_s;
                  if (rd_s == 4'h5) begin
                    sp_d = sp_q - 8'd1;
                  end else begin
                    sp_d = sp_q;
                  end
                end else begin
                  pc_d = pc_q;
                end
              end
              4'hF: begin
                case (rd_s)
                  4'h0: begin pc_d = m_slv2mst_data; sp_d = sp_q + 8'd1; end
                  4'h1: begin
                    {ie_d, n_d, c_d, z_d} = m_slv2mst_data[3:0];
                    sp_d    = sp_q + 8'd1;
                    state_d = ST_EXEC2;
                  end
                  4'h2:    ie_d = 1'b0;
                  4'h3:    ie_d = 1'b1;
                  default: begin end
                endcase
              end
              default: begin end
            endcase
          end
        end
      end
      ST_EXEC2: begin
        if (stall_s) begin
          state_d = ST_EXEC2;
        end else begin
          pc_d    = m_slv2mst_data;
          sp_d    = sp_q + 8'd1;
          state_d = exec_next_s;
        end
      end
      ST_INT1: begin
        if (stall_s) begin
          state_d = ST_INT1;
        end else begin
          sp_d    = sp_q - 8'd1;
          state_d = ST_INT2;
        end
      end
      ST_INT2: begin
        if (stall_s) begin
          state_d = ST_INT2;
        end else begin
          sp_d    = sp_q - 8'd1;
          ie_d    = 1'b0;
          pc_d    = IRQ_VECTOR;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RST_PC;
      sp_q    <= RST_SP;
      ir_q    <= 16'h0000;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      ie_q    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      ie_q    <= ie_d;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign cpu2pmem_addr = pc_q;
  assign SP            = sp_q;
  assign cpu2dbg_data  = {pc_q, ir_q, rf_q[0], sp_q, 4'b0000, ie_q, n_q, c_q, z_q};

endmodule

// File: tb/tb_minirisc_core.sv
// Testbench for minirisc_core: directed scenarios plus random programs checked
// by a bus-transaction scoreboard fed from an instruction-level reference model.
module tb_minirisc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cpu2pmem_addr;
  logic [15:0] pmem2cpu_data;
  logic        m_bus_req;
  logic        m_bus_grant = 1'b1;
  logic [7:0]  m_mst2slv_addr;
  logic        m_mst2slv_wr, m_mst2slv_rd;
  logic [7:0]  m_mst2slv_data, m_slv2mst_data;
  logic        irq = 1'b0;
  logic [7:0]  SP;
  logic [7:0]  dbg_stack_top;
  logic [22:0] dbg2cpu_data;
  logic [47:0] cpu2dbg_data;

  logic [15:0] pmem [256];
  logic [7:0]  dmem [256];

  int n_checks = 0;
  int n_err    = 0;
  int seen     = 0;
  int wr_cnt   = 0;
  bit rand_grant = 1'b0;
  logic [16:0] exp_q [$];

  // reference model state
  logic [7:0] m_pc, m_sp;
  logic [7:0] m_r [16];
  logic [7:0] m_mem [256];
  logic       m_z, m_c, m_n, m_ie;

  minirisc_core dut (
    .clk(clk), .rst(rst),
    .cpu2pmem_addr(cpu2pmem_addr), .pmem2cpu_data(pmem2cpu_data),
    .m_bus_req(m_bus_req), .m_bus_grant(m_bus_grant),
    .m_mst2slv_addr(m_mst2slv_addr), .m_mst2slv_wr(m_mst2slv_wr),
    .m_mst2slv_rd(m_mst2slv_rd), .m_mst2slv_data(m_mst2slv_data),
    .m_slv2mst_data(m_slv2mst_data), .irq(irq), .SP(SP),
    .dbg_stack_top(dbg_stack_top), .dbg2cpu_data(dbg2cpu_data),
    .cpu2dbg_data(cpu2dbg_data)
  );

  always #5 clk = ~clk;

  assign pmem2cpu_data  = pmem[cpu2pmem_addr];
  assign m_slv2mst_data = dmem[m_mst2slv_addr];
  assign dbg_stack_top  = dmem[SP];
  assign dbg2cpu_data   = 23'h0;

  // data memory write port
  initial forever begin
    @(posedge clk);
    if (!rst && m_mst2slv_wr) dmem[m_mst2slv_addr] <= m_mst2slv_data;
  end

  // random grant driver
  initial forever begin
    @(posedge clk); #1;
    if (rand_grant) m_bus_grant = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every granted bus access is popped against the scoreboard
  initial forever begin
    logic [16:0] got, want;
    @(negedge clk);
    if (!rst && (m_mst2slv_wr || m_mst2slv_rd)) begin
      got = {m_mst2slv_wr, m_mst2slv_addr, m_mst2slv_wr ? m_mst2slv_data : m_slv2mst_data};
      seen++;
      if (m_mst2slv_wr) wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL bus_txn: got unexpected %0h, expected none", got);
      end else begin
        want = exp_q.pop_front();
        check("bus_txn", {47'h0, got}, {47'h0, want});
      end
    end
  end

  task automatic expect_txn(input logic wr, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({wr, a, d});
  endtask

  // ---------------- reference model (instruction level) ----------------
  task automatic model_reset();
    m_pc = 8'h00; m_sp = 8'h7F;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_ie = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
  endtask

  task automatic model_alu(input logic [3:0] f, input logic [3:0] d, input logic [7:0] b);
    int a, r;
    a = int'(m_r[d]);
    r = 0;
    case (f)
      4'h0: begin m_r[d] = b; return; end
      4'h1: begin r = a + int'(b); m_c = (r > 255); end
      4'h2, 4'h6: begin r = a - int'(b); m_c = (a < int'(b)); end
      4'h3: begin r = a & int'(b); m_c = 1'b0; end
      4'h4: begin r = a | int'(b); m_c = 1'b0; end
      4'h5: begin r = a ^ int'(b); m_c = 1'b0; end
      default: return;
    endcase
    r = r & 255;
    m_z = (r == 0);
    m_n = (r >= 128);
    if (f != 4'h6) m_r[d] = r[7:0];
  endtask

  task automatic model_pop(output logic [7:0] v);
    v = m_mem[m_sp];
    expect_txn(1'b0, m_sp, v);
    m_sp = m_sp + 8'd1;
  endtask

  task automatic model_push(input logic [7:0] v);
    m_sp = m_sp - 8'd1;
    m_mem[m_sp] = v;
    expect_txn(1'b1, m_sp, v);
  endtask

  task automatic model_step();
    logic [15:0] w;
    logic [3:0]  op, d;
    logic [7:0]  imm, v;
    bit          take;
    w = pmem[m_pc];
    m_pc = m_pc + 8'd1;
    op = w[15:12]; d = w[11:8]; imm = w[7:0];
    if (op <= 4'h6) model_alu(op, d, imm);
    else if (op == 4'hA) model_alu(w[3:0], d, m_r[w[7:4]]);
    else if (op == 4'h8) begin
      m_r[d] = m_mem[imm];
      expect_txn(1'b0, imm, m_mem[imm]);
    end else if (op == 4'h9) begin
      m_mem[imm] = m_r[d];
      expect_txn(1'b1, imm, m_r[d]);
    end else if (op == 4'hB) begin
      if (w[0] == 1'b0) model_push(m_r[d]);
      else begin model_pop(v); m_r[d] = v; end
    end else if (op == 4'hE) begin
      take = (d == 4'h0) || (d == 4'h1 && m_z) || (d == 4'h2 && !m_z) ||
             (d == 4'h3 && m_c) || (d == 4'h4 && !m_c) || (d == 4'h5);
      if (d == 4'h5) model_push(m_pc);
      if (take) m_pc = imm;
    end else if (op == 4'hF) begin
      if (d == 4'h0) begin model_pop(v); m_pc = v; end
      else if (d == 4'h1) begin
        model_pop(v); {m_ie, m_n, m_c, m_z} = v[3:0];
        model_pop(v); m_pc = v;
      end
      else if (d == 4'h2) m_ie = 1'b0;
      else if (d == 4'h3) m_ie = 1'b1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rand_grant = 1'b0; m_bus_grant = 1'b1; irq = 1'b0;
    cyc(2);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 16'h7000;
      dmem[i] <= 8'h00;
    end
    exp_q.delete();
    wr_cnt = 0;
    seen   = 0;
  endtask

  task automatic end_test(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] pcs;
    logic        busy;

    // reset state
    do_reset();
    @(negedge clk);
    check("reset_dbg", cpu2dbg_data, 48'h00_0000_00_7F_00);
    check("reset_bus", {m_bus_req, m_mst2slv_wr, m_mst2slv_rd, m_mst2slv_addr, m_mst2slv_data}, 0);

    // jump sequence, no bus activity
    clear_mem();
    pmem[8'h00] = 16'hE005; pmem[8'h05] = 16'hE000;
    cyc(1); rst = 1'b0;
    @(negedge clk);
    pcs = {56'h0, cpu2pmem_addr};
    busy = m_bus_req | m_mst2slv_wr | m_mst2slv_rd;
    for (int i = 0; i < 7; i++) begin
      cyc(1); @(negedge clk);
      pcs = {pcs[55:0], cpu2pmem_addr};
      busy = busy | m_bus_req | m_mst2slv_wr | m_mst2slv_rd;
    end
    check("jump_pc_seq", pcs, 64'h00_01_05_06_00_01_05_06);
    check("jump_no_bus", busy, 0);
    end_test("jump_leftover");

    // LD then ST
    do_reset(); clear_mem();
    pmem[8'h00] = 16'h8101; pmem[8'h01] = 16'h9110; pmem[8'h02] = 16'hE002;
    dmem[8'h01] <= 8'hBA;
    expect_txn(1'b0, 8'h01, 8'hBA); expect_txn(1'b1, 8'h10, 8'hBA);
    rst = 1'b0;
    cyc(1); @(negedge clk);
    check("ld_bus_cycle", {m_bus_req, m_mst2slv_rd, m_mst2slv_wr, m_mst2slv_addr}, {1'b1, 1'b1, 1'b0, 8'h01});
    cyc(1); @(negedge clk);
    check("ld_fetch_idle", m_bus_req, 0);
    cyc(2); @(negedge clk);
    check("ld_st_mem", dmem[8'h10], 8'hBA);
    check("ld_z_flag", cpu2dbg_data[0], 0);
    end_test("ld_leftover");

    // PUSH / POP
    do_reset(); clear_mem();
    pmem[8'h00] = 16'h8101; pmem[8'h01] = 16'hB100; pmem[8'h02] = 16'hB201;
    pmem[8'h03] = 16'h9211; pmem[8'h04] = 16'hE004;
    dmem[8'h01] <= 8'hBA; dmem[8'h7F] <= 8'hCC;
    expect_txn(1'b0, 8'h01, 8'hBA); expect_txn(1'b1, 8'h7E, 8'hBA);
    expect_txn(1'b0, 8'h7E, 8'hBA); expect_txn(1'b1, 8'h11, 8'hBA);
    rst = 1'b0;
    cyc(4); @(negedge clk);
    check("push_sp", SP, 8'h7E);
    cyc(2); @(negedge clk);
    check("pop_sp_top", {SP, dbg_stack_top}, {8'h7F, 8'hCC});
    cyc(2); @(negedge clk);
    check("pop_r2_mem", dmem[8'h11], 8'hBA);
    end_test("stack_leftover");

    // grant withheld for 3 cycles during ST
    do_reset(); clear_mem();
    pmem[8'h00] = 16'h015A; pmem[8'h01] = 16'h9120; pmem[8'h02] = 16'hE002;
    expect_txn(1'b1, 8'h20, 8'h5A);
    rst = 1'b0;
    cyc(3); m_bus_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_cycle", {m_bus_req, m_mst2slv_wr, m_mst2slv_rd, m_mst2slv_addr, m_mst2slv_data},
            {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
      cyc(1);
    end
    m_bus_grant = 1'b1;
    @(negedge clk);
    check("stall_write", {m_bus_req, m_mst2slv_wr, m_mst2slv_rd, m_mst2slv_addr, m_mst2slv_data},
          {1'b1, 1'b1, 1'b0, 8'h20, 8'h5A});
    cyc(3); @(negedge clk);
    check("stall_wr_count", wr_cnt, 1);
    check("stall_mem", dmem[8'h20], 8'h5A);
    end_test("stall_leftover");

    // reset during a write access aborts it
    do_reset(); clear_mem();
    pmem[8'h00] = 16'h015A; pmem[8'h01] = 16'h9120; pmem[8'h02] = 16'hE002;
    rst = 1'b0;
    cyc(3); rst = 1'b1;
    @(negedge clk);
    check("rst_abort_bus", {m_bus_req, m_mst2slv_wr, m_mst2slv_addr}, 0);
    cyc(2); @(negedge clk);
    check("rst_abort_mem", dmem[8'h20], 8'h00);
    end_test("rst_abort_leftover");

    // interrupt entry and RTI
    do_reset(); clear_mem();
    pmem[8'h00] = 16'hE010; pmem[8'h10] = 16'hF300; pmem[8'h11] = 16'hE011;
    pmem[8'h01] = 16'h0377; pmem[8'h02] = 16'hF100;
    expect_txn(1'b1, 8'h7E, 8'h11); expect_txn(1'b1, 8'h7D, 8'h08);
    expect_txn(1'b0, 8'h7D, 8'h08); expect_txn(1'b0, 8'h7E, 8'h11);
    rst = 1'b0;
    cyc(4); irq = 1'b1;
    cyc(4); irq = 1'b0;
    @(negedge clk);
    check("irq_entry", {cpu2pmem_addr, cpu2dbg_data[3], SP}, {8'h01, 1'b0, 8'h7D});
    cyc(5); @(negedge clk);
    check("rti_restore", {cpu2pmem_addr, cpu2dbg_data[3], SP}, {8'h11, 1'b1, 8'h7F});
    end_test("irq_leftover");

    // ALU flags
    do_reset(); clear_mem();
    pmem[8'h00] = 16'h00FF; pmem[8'h01] = 16'h1001; pmem[8'h02] = 16'h6001; pmem[8'h03] = 16'hE003;
    rst = 1'b0;
    cyc(2); @(negedge clk);
    check("mov_no_flags", {cpu2dbg_data[23:16], cpu2dbg_data[3:0]}, {8'hFF, 4'b0000});
    cyc(2); @(negedge clk);
    check("add_wrap", {cpu2dbg_data[23:16], cpu2dbg_data[3:0]}, {8'h00, 4'b0011});
    cyc(2); @(negedge clk);
    check("cmp_borrow", {cpu2dbg_data[23:16], cpu2dbg_data[3:0]}, {8'h00, 4'b0110});
    end_test("alu_leftover");

    // random programs against the reference model, random grant stalls
    for (int p = 0; p < 4; p++) begin
      int target;
      logic [7:0] v;
      do_reset(); clear_mem();
      for (int i = 0; i < 256; i++) begin
        pmem[i] = 16'($urandom);
        v = 8'($urandom);
        dmem[i] <= v;
        m_mem[i] = v;
      end
      model_reset();
      for (int k = 0; k < 300; k++) model_step();
      target = exp_q.size();
      rand_grant = 1'b1;
      rst = 1'b0;
      for (int k = 0; k < 4000 && seen < target; k++) begin
        @(negedge clk); #1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      rand_grant = 1'b0;
      check("rand_txn_count", seen, target);
      end_test("rand_leftover");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/minirisc_core.md
Name: minirisc_core

Overview:
- 8-bit multicycle MiniRISC-style CPU with a 256x16 program memory port and an 8-bit data-bus master interface.
- Contains a built-in 2-master fixed-priority bus request/grant gate. When the grant is withheld, the CPU stalls.
- Provides a stack in data memory, level-sensitive interrupts, and a flat debug snapshot bus.
- Sits between program memory, data memory and the system bus in the MiniRISC system.

Parameters:
- RST_PC, 8'h00, PC value after reset.
- RST_SP, 8'h7F, SP value after reset (empty-stack marker).
- IRQ_VECTOR, 8'h01, interrupt entry address.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu2pmem_addr  out  8  program address; equals PC
- pmem2cpu_data  in  16  instruction word, combinational read
- m_bus_req  out  1  high during every data-bus access cycle
- m_bus_grant  in  1  bus granted (combinational, same cycle)
- m_mst2slv_addr  out  8  data address; 0 when not granted or no access
- m_mst2slv_wr  out  1  write strobe
- m_mst2slv_rd  out  1  read strobe
- m_mst2slv_data  out  8  write data; 0 when not writing
- m_slv2mst_data  in  8  read data, combinational, sampled at cycle end
- irq  in  1  interrupt request, active-high, level-sensitive
- SP  out  8  current stack pointer
- dbg_stack_top  in  8  data_mem[SP]; included in the debug bus only
- dbg2cpu_data  in  23  reserved; ignored
- cpu2dbg_data  out  48  {PC, IR[15:0], r0, SP, 4'b0, IE, N, C, Z}

Behaviour:
- Reset (synchronous):
  - PC=RST_PC, SP=RST_SP, IR=0, flags and IE=0.
  - r0..r15=0, state=FETCH.
  - All bus outputs are 0.
- FETCH (1 cycle): IR<=pmem2cpu_data, PC<=PC+1 (wraps 0xFF->0x00), then go to EXEC.
- Instruction format: op=IR[15:12], rd=IR[11:8], imm/addr=IR[7:0], rs=IR[7:4], aluop=IR[3:0].
- Immediate ALU ops:
  - 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 CMP (SUB without writeback).
- Op 0xA, register ALU: aluop 0..6 as above, using rs as the operand.
- Flags:
  - Z = result==0.
  - N = result[7].
  - C = carry out (ADD) or borrow (SUB/CMP).
  - Logic ops clear C.
  - MOV leaves all flags unchanged.
- Memory ops (each uses one bus cycle in EXEC):
  - 0x8 LD rd,(addr).
  - 0x9 ST (addr),rd.
  - 0xB with IR[0]=0: PUSH rd = SP<=SP-1 then write mem[SP-1].
  - 0xB with IR[0]=1: POP rd = read mem[SP], then SP<=SP+1.
- Op 0xE, jumps to addr, selected by IR[11:8]:
  - 0 JMP, 1 JZ, 2 JNZ, 3 JC, 4 JNC.
  - 5 JSR: push PC (return address), then jump.
  - Untaken jumps take 2 cycles total.
- Op 0xF, selected by IR[11:8]:
  - 0 RTS: pop PC.
  - 1 RTI: pop flags, then pop PC.
  - 2 CLI: IE<=0.
  - 3 STI: IE<=1.
- Undefined opcodes execute as NOP.
- Timing:
  - All instructions take 2 cycles (FETCH+EXEC), except RTI which takes 3.
  - Each bus cycle extends while m_bus_grant=0: m_bus_req stays high, strobes stay 0, and no state changes.
- Interrupt entry:
  - Checked at the end of every EXEC; if irq and IE, go to INT1 instead of FETCH.
  - INT1: push PC.
  - INT2: push {4'b0, IE, N, C, Z}, set IE<=0, PC<=IRQ_VECTOR.
  - Then FETCH.
  - irq is not latched: if it drops before the EXEC end, no interrupt is taken.
- SP wraps modulo 256; there is no overflow detection.
- Reset asserted mid-access aborts the access immediately; no write occurs in that cycle.
- Internal arbiter:
  - Master 0 (the CPU's own req) has fixed priority over master 1.
  - Master 1 is tied off, so grant = req & m_bus_grant.

Test Plan:
- pmem[0]=E005, pmem[5]=E000, reset released -> cpu2pmem_addr sequence 00,01,05,06,00,... every 2 cycles; no bus activity.
- LD r1,(0x01) with mem[1]=BA -> m_bus_req=1, m_mst2slv_rd=1, addr=01 for one cycle; r1=BA visible via ST to 0x10; Z=0.
- PUSH r1 from reset -> SP=7E, write to 7E with data BA; POP r2 -> SP=7F, r2=BA; dbg_stack_top then reads CC.
- Hold m_bus_grant=0 for 3 cycles during ST -> m_bus_req=1 with strobes 0 for those 3 cycles; exactly one write occurs once grant rises.
- STI, then irq=1 -> pushes of PC and flags (IE=1), PC=01, IE=0; RTI restores PC and IE=1.
- MOV r0,#FF; ADD r0,#01 -> r0=00, Z=1, C=1; CMP r0,#01 -> C=1, N=1.
